// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: opcodes, FSM encoding and
// instruction field positions.
package alu_ctrl_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned NREGS  = 4;

   // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm8
   localparam int unsigned OP_HI  = 15;
   localparam int unsigned OP_LO  = 12;
   localparam int unsigned RD_HI  = 11;
   localparam int unsigned RD_LO  = 10;
   localparam int unsigned RS_HI  = 9;
   localparam int unsigned RS_LO  = 8;
   localparam int unsigned IMM_HI = 7;
   localparam int unsigned IMM_LO = 0;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_OR  = 4'b0011,
      OP_XOR = 4'b0100,
      OP_SHL = 4'b0101,
      OP_SHR = 4'b0110,
      OP_NOT = 4'b0111,
      OP_LDR = 4'b1000,
      OP_STR = 4'b1001,
      OP_LDI = 4'b1010,
      OP_RSV = 4'b1011,
      OP_JMP = 4'b1100,
      OP_BNE = 4'b1101,
      OP_BEQ = 4'b1110,
      OP_NOP = 4'b1111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MEM  = 2'd2
   } state_e;

   function automatic logic [DATA_W-1:0] zext_imm(input logic [7:0] imm);
      return {8'h00, imm};
   endfunction

endpackage

// File: rtl/ctrl_regfile.sv
// Four-entry register file: one write port, two operand read ports and a
// combinational debug read port.
module ctrl_regfile
   import alu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [1:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [1:0]        raddr_a_i,
   input  logic [1:0]        raddr_b_i,
   input  logic [1:0]        dbg_sel_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] regs_q [NREGS];

   // NOTE: this storage is tiny and must read as zero after reset, so it is a
   // reset flop array rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o  = regs_q[raddr_a_i];
   assign rdata_b_o  = regs_q[raddr_b_i];
   assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_controller.sv
// Multi-cycle controller that decodes 16-bit instructions, drives an external
// ALU/memory datapath and keeps the register file and {Z,N,C,V} flags.
module alu_controller
   import alu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              mem_en,
   output logic              mem_wr_en,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_c,
   input  logic              alu_v,
   output logic              done,
   output logic              err,
   output logic [3:0]        flags,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            state_q, state_d;
   logic [15:0]       ir_q, ir_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [3:0]        flags_q, flags_d;

   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rd_val, rs_val;
   logic              upd_flags;

   opcode_e           op;
   logic [1:0]        rd_idx, rs_idx;
   logic [DATA_W-1:0] imm_ext;

   assign op      = opcode_e'(ir_q[OP_HI:OP_LO]);
   assign rd_idx  = ir_q[RD_HI:RD_LO];
   assign rs_idx  = ir_q[RS_HI:RS_LO];
   assign imm_ext = zext_imm(ir_q[IMM_HI:IMM_LO]);

   ctrl_regfile u_regfile (
      .clk        (clk),
      .rst_n      (rst),
      .we_i       (rf_we),
      .waddr_i    (rd_idx),
      .wdata_i    (rf_wdata),
      .raddr_a_i  (rd_idx),
      .raddr_b_i  (rs_idx),
      .dbg_sel_i  (dbg_sel),
      .rdata_a_o  (rd_val),
      .rdata_b_o  (rs_val),
      .dbg_data_o (dbg_data)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ir_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         done_q  <= done_d;
         err_q   <= err_d;
         flags_q <= flags_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      flags_d     = flags_q;
      rf_we       = 1'b0;
      rf_wdata    = alu_result;
      upd_flags   = 1'b0;
      instr_ready = 1'b0;
      alu_op      = OP_NOP;
      alu_a       = '0;
      alu_b       = '0;
      mem_en      = 1'b0;
      mem_wr_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d    = instr;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                  alu_op    = op;
                  alu_a     = rd_val;
                  alu_b     = rs_val;
                  rf_we     = 1'b1;
                  upd_flags = 1'b1;
               end
               OP_NOT: begin
                  alu_op    = OP_NOT;
                  alu_a     = rd_val;
                  rf_we     = 1'b1;
                  upd_flags = 1'b1;
               end
               OP_LDR: begin
                  alu_op  = OP_LDR;
                  alu_b   = imm_ext;
                  mem_en  = 1'b1;
                  state_d = ST_MEM;
                  done_d  = 1'b0;
               end
               OP_STR: begin
                  alu_op    = OP_STR;
                  alu_a     = rd_val;
                  alu_b     = imm_ext;
                  mem_en    = 1'b1;
                  mem_wr_en = 1'b1;
               end
               OP_LDI: begin
                  rf_we    = 1'b1;
                  rf_wdata = imm_ext;
               end
               OP_JMP: begin
                  alu_op = OP_JMP;
                  alu_b  = imm_ext;
               end
               // Branch condition is resolved here from the latched Z flag
               OP_BNE: begin
                  alu_op = flags_q[3] ? OP_NOP : OP_JMP;
                  alu_b  = imm_ext;
               end
               OP_BEQ: begin
                  alu_op = flags_q[3] ? OP_JMP : OP_NOP;
                  alu_b  = imm_ext;
               end
               OP_RSV:  err_d = 1'b1;
               default: ;
            endcase
         end
         ST_MEM: begin
            alu_op    = OP_LDR;
            alu_b     = imm_ext;
            mem_en    = 1'b1;
            rf_we     = 1'b1;
            upd_flags = 1'b1;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (upd_flags) flags_d = {alu_result == '0, alu_result[15], alu_c, alu_v};
   end

   assign done  = done_q;
   assign err   = err_q;
   assign flags = flags_q;

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller: a behavioural ALU/memory environment, a
// table of instruction vectors and hand-written multi-cycle sequences.
module tb_alu_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [3:0]  alu_op;
   logic [15:0] alu_a, alu_b;
   logic        mem_en, mem_wr_en;
   logic [15:0] alu_result;
   logic        alu_c, alu_v;
   logic        done, err;
   logic [3:0]  flags;
   logic [1:0]  dbg_sel;
   logic [15:0] dbg_data;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_controller dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .mem_en      (mem_en),
      .mem_wr_en   (mem_wr_en),
      .alu_result  (alu_result),
      .alu_c       (alu_c),
      .alu_v       (alu_v),
      .done        (done),
      .err         (err),
      .flags       (flags),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data)
   );

   // Environment: the ALU and a 256-word data memory seen by the controller
   logic [15:0] mem [256];
   logic [16:0] wide;

   always_comb begin
      wide       = '0;
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (alu_op)
         4'h0: begin
            wide       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = wide[15:0];
            alu_c      = wide[16];
            alu_v      = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
         end
         4'h1: begin
            wide       = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result = wide[15:0];
            alu_c      = wide[16];
            alu_v      = (alu_a[15] != alu_b[15]) && (wide[15] != alu_a[15]);
         end
         4'h2:    alu_result = alu_a & alu_b;
         4'h3:    alu_result = alu_a | alu_b;
         4'h4:    alu_result = alu_a ^ alu_b;
         4'h5:    alu_result = alu_a << alu_b[3:0];
         4'h6:    alu_result = alu_a >> alu_b[3:0];
         4'h7:    alu_result = ~alu_a;
         4'h8:    alu_result = mem[alu_b[7:0]];
         default: alu_result = '0;
      endcase
   end

   always @(posedge clk) if (mem_en && mem_wr_en) mem[alu_b[7:0]] <= alu_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Snapshot of the cycle after accept (EXEC) and, for LDR, the MEM cycle
   logic [3:0]  ex_op, mem_op;
   logic [15:0] ex_a, ex_b, mem_b;
   logic        ex_men, ex_wr, ex_rdy, mem_men, err_seen;
   int          wr_cycles, lat;

   task automatic run_instr(input logic [15:0] ins);
      int k;
      @(negedge clk);
      instr       = ins;
      instr_valid = 1'b1;
      check($sformatf("accept_ready_%04h", ins), instr_ready, 1);
      @(posedge clk);
      k         = 1;
      wr_cycles = 0;
      @(negedge clk);
      instr_valid = 1'b0;
      ex_op  = alu_op;
      ex_a   = alu_a;
      ex_b   = alu_b;
      ex_men = mem_en;
      ex_wr  = mem_wr_en;
      ex_rdy = instr_ready;
      while (!done && k < 8) begin
         if (mem_wr_en) wr_cycles++;
         @(posedge clk);
         k++;
         @(negedge clk);
         if (k == 2) begin
            mem_op  = alu_op;
            mem_b   = alu_b;
            mem_men = mem_en;
         end
      end
      lat      = k;
      err_seen = err;
   endtask

   typedef struct {
      logic [15:0] ins;
      int          lat;
      logic        err;
      logic [3:0]  op;
      logic        chk_a;
      logic [15:0] a;
      logic        chk_b;
      logic [15:0] b;
      logic        men;
      logic        wr;
      logic [1:0]  sel;
      logic [15:0] val;
      logic [3:0]  flg;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [15:0] ins, input int lt, input logic e,
                               input logic [3:0] op, input logic ca, input logic [15:0] a,
                               input logic cb, input logic [15:0] b, input logic men,
                               input logic wr, input logic [1:0] sel, input logic [15:0] val,
                               input logic [3:0] flg);
      vec_t v;
      v.ins = ins; v.lat = lt; v.err = e; v.op = op; v.chk_a = ca; v.a = a;
      v.chk_b = cb; v.b = b; v.men = men; v.wr = wr; v.sel = sel; v.val = val; v.flg = flg;
      return v;
   endfunction

   initial begin
      int acc, busy, dn;
      rst         = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      dbg_sel     = 2'd0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", instr_ready, 1);
      check("rst_op", alu_op, 4'hF);
      check("rst_a", alu_a, 0);
      check("rst_b", alu_b, 0);
      check("rst_men", {mem_en, mem_wr_en}, 0);
      check("rst_done_err", {done, err}, 0);
      check("rst_flags", flags, 0);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1 check($sformatf("rst_r%0d", r), dbg_data, 0);
      end
      rst = 1'b1;

      //                ins      lat err op   ca a        cb b        men wr sel val      flg
      vecs.push_back(mk(16'hA405, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0005, 4'b0000)); // LDI R1,5
      vecs.push_back(mk(16'hA803, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 2, 16'h0003, 4'b0000)); // LDI R2,3
      vecs.push_back(mk(16'h0600, 2, 0, 4'h0, 1, 16'h0005, 1, 16'h0003, 0, 0, 1, 16'h0008, 4'b0000)); // ADD R1,R2
      vecs.push_back(mk(16'hA001, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0001, 4'b0000)); // LDI R0,1
      vecs.push_back(mk(16'h1000, 2, 0, 4'h1, 1, 16'h0001, 1, 16'h0001, 0, 0, 0, 16'h0000, 4'b1000)); // SUB R0,R0
      vecs.push_back(mk(16'hE040, 2, 0, 4'hC, 0, 16'h0000, 1, 16'h0040, 0, 0, 0, 16'h0000, 4'b1000)); // BEQ taken
      vecs.push_back(mk(16'hD040, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b1000)); // BNE not taken
      vecs.push_back(mk(16'hA412, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0012, 4'b1000)); // LDI R1,0x12
      vecs.push_back(mk(16'hAC08, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 16'h0008, 4'b1000)); // LDI R3,8
      vecs.push_back(mk(16'h5700, 2, 0, 4'h5, 1, 16'h0012, 1, 16'h0008, 0, 0, 1, 16'h1200, 4'b0000)); // SHL R1,R3
      vecs.push_back(mk(16'hAC34, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 16'h0034, 4'b0000)); // LDI R3,0x34
      vecs.push_back(mk(16'h3700, 2, 0, 4'h3, 1, 16'h1200, 1, 16'h0034, 0, 0, 1, 16'h1234, 4'b0000)); // OR R1,R3
      vecs.push_back(mk(16'hAC00, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 3, 16'h0000, 4'b0000)); // LDI R3,0
      vecs.push_back(mk(16'h9410, 2, 0, 4'h9, 1, 16'h1234, 1, 16'h0010, 1, 1, 3, 16'h0000, 4'b0000)); // STR R1,0x10
      vecs.push_back(mk(16'h8C10, 3, 0, 4'h8, 0, 16'h0000, 1, 16'h0010, 1, 0, 3, 16'h1234, 4'b0000)); // LDR R3,0x10
      vecs.push_back(mk(16'h7800, 2, 0, 4'h7, 1, 16'h0003, 1, 16'h0000, 0, 0, 2, 16'hFFFC, 4'b0100)); // NOT R2
      vecs.push_back(mk(16'h0A00, 2, 0, 4'h0, 1, 16'hFFFC, 1, 16'hFFFC, 0, 0, 2, 16'hFFF8, 4'b0110)); // ADD R2,R2
      vecs.push_back(mk(16'hBFFF, 2, 1, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 2, 16'hFFF8, 4'b0110)); // reserved
      vecs.push_back(mk(16'hC0AA, 2, 0, 4'hC, 0, 16'h0000, 1, 16'h00AA, 0, 0, 1, 16'h1234, 4'b0110)); // JMP
      vecs.push_back(mk(16'hD055, 2, 0, 4'hC, 0, 16'h0000, 1, 16'h0055, 0, 0, 3, 16'h1234, 4'b0110)); // BNE taken
      vecs.push_back(mk(16'hE055, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 4'b0110)); // BEQ not taken
      vecs.push_back(mk(16'hF000, 2, 0, 4'hF, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h1234, 4'b0110)); // NOP

      foreach (vecs[i]) begin
         run_instr(vecs[i].ins);
         check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("v%0d_err", i), err_seen, vecs[i].err);
         check($sformatf("v%0d_exec_ready", i), ex_rdy, 0);
         check($sformatf("v%0d_op", i), ex_op, vecs[i].op);
         if (vecs[i].chk_a) check($sformatf("v%0d_a", i), ex_a, vecs[i].a);
         if (vecs[i].chk_b) check($sformatf("v%0d_b", i), ex_b, vecs[i].b);
         check($sformatf("v%0d_men", i), ex_men, vecs[i].men);
         check($sformatf("v%0d_wr", i), ex_wr, vecs[i].wr);
         check($sformatf("v%0d_wr_cycles", i), wr_cycles, 32'(vecs[i].wr));
         if (vecs[i].lat == 3) begin
            check($sformatf("v%0d_mem_op", i), mem_op, 4'h8);
            check($sformatf("v%0d_mem_b", i), mem_b, vecs[i].b);
            check($sformatf("v%0d_mem_men", i), mem_men, 1);
         end
         dbg_sel = vecs[i].sel;
         #1;
         check($sformatf("v%0d_reg", i), dbg_data, vecs[i].val);
         check($sformatf("v%0d_flags", i), flags, vecs[i].flg);
      end

      // Three back-to-back ADD R0,R1 with instr_valid held high
      acc  = 0;
      busy = 0;
      dn   = 0;
      @(negedge clk);
      instr       = 16'h0100;
      instr_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (instr_ready) acc++;
         else busy++;
         if (done) dn++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (done) dn++;
         @(negedge clk);
      end
      check("b2b_accepts", acc, 3);
      check("b2b_busy", busy, 3);
      check("b2b_dones", dn, 3);
      dbg_sel = 2'd0;
      #1 check("b2b_r0", dbg_data, 16'h369C);
      check("b2b_flags", flags, 4'b0000);

      // Reset asserted during the MEM cycle of LDR R2,0x10
      @(negedge clk);
      instr       = 16'h8810;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_in_mem", {mem_en, alu_op}, {1'b1, 4'h8});
      #2 rst = 1'b0;
      #1;
      check("abort_ready", instr_ready, 1);
      check("abort_op", alu_op, 4'hF);
      check("abort_ab", {alu_a, alu_b}, 0);
      check("abort_men", {mem_en, mem_wr_en}, 0);
      check("abort_done_err", {done, err}, 0);
      check("abort_flags", flags, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      dn  = 0;
      for (int c = 0; c < 3; c++) begin
         if (done) dn++;
         @(negedge clk);
      end
      check("abort_no_done", dn, 0);
      dbg_sel = 2'd2;
      #1 check("abort_r2", dbg_data, 0);
      dbg_sel = 2'd1;
      #1 check("abort_r1", dbg_data, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_controller.md
ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 The module SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous, active-low reset
  instr_valid  in  1  instruction offered
  instr  in  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm8
  instr_ready  out  1  controller can accept
  alu_op  out  4  ALU OPsel drive
  alu_a  out  16  ALU A drive
  alu_b  out  16  ALU B drive (operand/address/jump target)
  mem_en  out  1  memory enable
  mem_wr_en  out  1  memory write enable
  alu_result  in  16  ALU result (equals mem_data for op 1000)
  alu_c, alu_v  in  1 each  ALU carry/overflow
  done  out  1  one-cycle pulse, instruction retired
  err  out  1  one-cycle pulse, reserved opcode retired
  flags  out  4  latched {Z,N,C,V}
  dbg_sel  in  2  register-file read select
  dbg_data  out  16  R[dbg_sel], combinational

Function
REQ-003 The controller SHALL have states IDLE, EXEC and MEM; instr_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE with instr_valid=1, the controller SHALL latch instr into IR and go to EXEC; instr_valid outside IDLE SHALL be ignored.
REQ-005 EXEC SHALL last exactly one cycle; MEM (LDR only) SHALL last exactly one cycle; both then return to IDLE.
REQ-006 The controller SHALL contain 4x16 registers R0-R3; all four are writable.
REQ-007 Ops 0000-0110 SHALL drive alu_a=R[rd], alu_b=R[rs] in EXEC and write alu_result to R[rd] at the end of EXEC.
REQ-008 Op 0111 (NOT) SHALL drive alu_a=R[rd], alu_b=0 and write alu_result to R[rd].
REQ-009 Op 1000 (LDR) SHALL drive alu_op=1000, mem_en=1, alu_b={8'h00,imm8} in EXEC and MEM, and write alu_result to R[rd] at the end of MEM.
REQ-010 Op 1001 (STR) SHALL drive alu_op=1001, alu_a=R[rd], alu_b={8'h00,imm8}, mem_en=1, mem_wr_en=1 for the EXEC cycle only.
REQ-011 Op 1010 (LDI) SHALL write {8'h00,imm8} to R[rd] at the end of EXEC with alu_op=1111.
REQ-012 Op 1100 SHALL drive alu_op=1100, alu_b={8'h00,imm8} in EXEC.
REQ-013 Ops 1101/1110 SHALL drive alu_op=1100 when latched Z is 0/1 respectively, and 1111 otherwise; the controller, not the ALU, evaluates the condition.
REQ-014 Op 1111 SHALL drive alu_op=1111.
REQ-015 Op 1011 SHALL drive alu_op=1111, modify no state, and pulse err with done.
REQ-016 Ops 0000-1000 SHALL update flags when R[rd] is written: Z=(value==0), N=value[15], C=alu_c, V=alu_v (C and V sampled in the same cycle as the value).
REQ-017 All other ops SHALL leave flags unchanged.
REQ-018 In IDLE the controller SHALL drive alu_op=1111, alu_a=alu_b=0, mem_en=mem_wr_en=0.
REQ-019 done SHALL be registered and SHALL be 1 for exactly the first IDLE cycle after retirement, so accept-to-done is 2 cycles (LDR: 3).
REQ-020 A new instruction MAY be accepted in the cycle where done=1.

Reset
REQ-021 While rst=0, the controller SHALL immediately be in IDLE with R0-R3=0, flags=0, IR=0, done=err=0, instr_ready=1 and the IDLE drive values of REQ-018, including mid-EXEC/MEM.
REQ-022 An instruction aborted by reset SHALL not retire or write any state.

Structure
REQ-023 Package alu_ctrl_pkg SHALL hold the opcode constants (0000-1111), the state encoding and the instruction field positions.
REQ-024 The register file SHALL be sub-module ctrl_regfile (one write port, two read ports plus the debug read port).

Verification
REQ-025 LDI R1,0x05; LDI R2,0x03; ADD R1,R2 -> dbg R1=0x0008, flags=0000, each done 2 cycles after accept.
REQ-026 LDI R0,0x01; SUB R0,R0 -> R0=0, Z=1; then BEQ 0x40 -> alu_op=1100, alu_b=0x0040 for one cycle; BNE 0x40 -> alu_op=1111.
REQ-027 STR R1 (0x1234) to 0x10, then LDR R3 from 0x10 -> one cycle with mem_wr_en=1, alu_a=0x1234; R3=0x1234 with done 3 cycles after LDR accept.
REQ-028 instr_valid held high across 3 back-to-back ADDs -> exactly 3 accepts, instr_ready=0 during each EXEC.
REQ-029 Op 1011 -> err=done=1 for one cycle, registers and flags unchanged.
REQ-030 rst=0 asserted during LDR MEM -> outputs at reset values immediately, R[rd] unchanged (0), no done.
